awb_gain: RTL and testbench

Gray-world auto white balance stage that sits directly upstream of the gamma stage and feeds it RGB888 video with the same vsync/hsync/den framing. Every frame it accumulates per-channel sums of valid, unclipped pixels. At each frame boundary a shared serial divider computes R and B gains relative to G, in Q4.8 format. The pixel path multiplies R and B by the active gains, saturates to 8 bits, and passes G through unchanged, all with a fixed 2-cycle latency.

---
 rtl/awb_gain.sv | 223 ++++++++++++++++++++++
 tb/tb_awb_gain.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/awb_gain.sv
// Gray-world AWB: per-frame channel sums, serial restoring divider -> Q4.8 R/B gains, gains applied to pixels.
// Fixed 2-cycle pixel latency, never stalls (no backpressure); gains update 2*(SW+8)+2 cycles after a vsync rise.
module awb_gain #(
    parameter int source_h = 1024,
    parameter int source_v = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awb_en,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic        in_den,
    input  logic [7:0]  in_data_R,
    input  logic [7:0]  in_data_G,
    input  logic [7:0]  in_data_B,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_data_R,
    output logic [7:0]  out_data_G,
    output logic [7:0]  out_data_B,
    output logic [11:0] gain_R,
    output logic [11:0] gain_B,
    output logic        awb_busy
);
    localparam int SW = 8 + $clog2(source_h * source_v);
    localparam int QW = SW + 8;
    localparam int CW = $clog2(QW);
    localparam logic [11:0]   UNITY = 12'd256;
    localparam logic [CW-1:0] LAST  = CW'(QW - 1);

    typedef enum logic [2:0] {IDLE, LATCH, DIV_R, DIV_B, DONE} state_t;

    state_t        state_q, state_d;
    logic          vsync_q;
    logic          frame_edge, pix_ok;
    logic [SW-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [SW-1:0] sum_r_d, sum_g_d, sum_b_d;
    logic [SW-1:0] lat_r_q, lat_g_q, lat_b_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] rem_q, dvs_q, rem_nx;
    logic [QW-1:0] quo_q, quo_nx;
    logic [SW:0]   rem_sh, rem_sub;
    logic          div_ge, div_last;
    logic [11:0]   q_sat;
    logic [11:0]   pend_r_q, pend_b_q, gain_r_q, gain_b_q;
    logic [11:0]   g_r, g_b;
    logic [19:0]   p1_r_q, p1_b_q;
    logic [7:0]    p1_g_q;
    logic          p1_vs_q, p1_hs_q, p1_den_q;
    logic [7:0]    out_r_q, out_g_q, out_b_q;
    logic          out_vs_q, out_hs_q, out_den_q;

    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] acc, input logic [7:0] px);
        logic [SW:0] s;
        s = {1'b0, acc} + {{(SW-7){1'b0}}, px};
        return s[SW] ? {SW{1'b1}} : s[SW-1:0];
    endfunction

    function automatic logic [7:0] round_sat(input logic [19:0] p);
        logic [20:0] s;
        s = {1'b0, p} + 21'd128;
        return (|s[20:16]) ? 8'hFF : s[15:8];
    endfunction

    // Statistics: a pixel on the boundary cycle seeds the new frame's sums.
    always_comb begin
        frame_edge = in_vsync & ~vsync_q;
        pix_ok     = in_den & (in_data_R != 8'hFF) & (in_data_G != 8'hFF) & (in_data_B != 8'hFF);
        sum_r_d    = frame_edge ? '0 : sum_r_q;
        sum_g_d    = frame_edge ? '0 : sum_g_q;
        sum_b_d    = frame_edge ? '0 : sum_b_q;
        if (pix_ok) begin
            sum_r_d = sat_add(sum_r_d, in_data_R);
            sum_g_d = sat_add(sum_g_d, in_data_G);
            sum_b_d = sat_add(sum_b_d, in_data_B);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            lat_r_q <= '0;
            lat_g_q <= '0;
            lat_b_q <= '0;
        end else begin
            vsync_q <= in_vsync;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            if (frame_edge) begin
                lat_r_q <= sum_r_q;
                lat_g_q <= sum_g_q;
                lat_b_q <= sum_b_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A new frame boundary always restarts the sequence, dropping any in-flight result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = IDLE;
            LATCH:   state_d = DIV_R;
            DIV_R:   if (div_last) state_d = DIV_B;
            DIV_B:   if (div_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (frame_edge) state_d = LATCH;
    end

    // Restoring step: dividend bits shift out of quo_q as quotient bits shift in.
    always_comb begin
        rem_sh   = {rem_q, quo_q[QW-1]};
        div_ge   = rem_sh >= {1'b0, dvs_q};
        rem_sub  = rem_sh - {1'b0, dvs_q};
        rem_nx   = div_ge ? rem_sub[SW-1:0] : rem_sh[SW-1:0];
        quo_nx   = {quo_q[QW-2:0], div_ge};
        q_sat    = (|quo_nx[QW-1:12]) ? 12'hFFF : quo_nx[11:0];
        div_last = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            pend_r_q <= UNITY;
            pend_b_q <= UNITY;
            gain_r_q <= UNITY;
            gain_b_q <= UNITY;
        end else begin
            unique case (state_q)
                LATCH: begin
                    cnt_q <= '0;
                    rem_q <= '0;
                    quo_q <= {lat_g_q, 8'h00};
                    dvs_q <= lat_r_q;
                end
                DIV_R: begin
                    if (div_last) begin
                        if (dvs_q != '0) pend_r_q <= q_sat;
                        cnt_q <= '0;
                        rem_q <= '0;
                        quo_q <= {lat_g_q, 8'h00};
                        dvs_q <= lat_b_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                    end
                end
                DIV_B: begin
                    if (div_last) begin
                        if (dvs_q != '0) pend_b_q <= q_sat;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                    end
                end
                DONE: begin
                    gain_r_q <= pend_r_q;
                    gain_b_q <= pend_b_q;
                end
                default: ;
            endcase
        end
    end

    assign g_r = awb_en ? gain_r_q : UNITY;
    assign g_b = awb_en ? gain_b_q : UNITY;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_r_q    <= '0;
            p1_g_q    <= '0;
            p1_b_q    <= '0;
            p1_vs_q   <= 1'b0;
            p1_hs_q   <= 1'b0;
            p1_den_q  <= 1'b0;
            out_r_q   <= '0;
            out_g_q   <= '0;
            out_b_q   <= '0;
            out_vs_q  <= 1'b0;
            out_hs_q  <= 1'b0;
            out_den_q <= 1'b0;
        end else begin
            p1_r_q    <= {12'd0, in_data_R} * {8'd0, g_r};
            p1_g_q    <= in_data_G;
            p1_b_q    <= {12'd0, in_data_B} * {8'd0, g_b};
            p1_vs_q   <= in_vsync;
            p1_hs_q   <= in_hsync;
            p1_den_q  <= in_den;
            out_r_q   <= round_sat(p1_r_q);
            out_g_q   <= p1_g_q;
            out_b_q   <= round_sat(p1_b_q);
            out_vs_q  <= p1_vs_q;
            out_hs_q  <= p1_hs_q;
            out_den_q <= p1_den_q;
        end
    end

    assign out_data_R = out_r_q;
    assign out_data_G = out_g_q;
    assign out_data_B = out_b_q;
    assign out_vsync  = out_vs_q;
    assign out_hsync  = out_hs_q;
    assign out_den    = out_den_q;
    assign gain_R     = gain_r_q;
    assign gain_B     = gain_b_q;
    assign awb_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_awb_gain.sv
// Bench for awb_gain: randomized and directed frames scored cycle-by-cycle against a frame-level reference model.
module tb_awb_gain;
    localparam int     N    = 36;              // SW + 8 at default geometry
    localparam longint SMAX = (64'd1 << 28) - 1;

    logic        clk = 1'b0;
    logic        reset, awb_en, in_vsync, in_hsync, in_den;
    logic [7:0]  in_data_R, in_data_G, in_data_B;
    logic        out_vsync, out_hsync, out_den;
    logic [7:0]  out_data_R, out_data_G, out_data_B;
    logic [11:0] gain_R, gain_B;
    logic        awb_busy;

    always #5 clk = ~clk;

    awb_gain dut (
        .clk(clk), .reset(reset), .awb_en(awb_en),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
        .in_data_R(in_data_R), .in_data_G(in_data_G), .in_data_B(in_data_B),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_data_R(out_data_R), .out_data_G(out_data_G), .out_data_B(out_data_B),
        .gain_R(gain_R), .gain_B(gain_B), .awb_busy(awb_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: frame sums, scheduled gain updates, 2-deep output delay line.
    typedef struct {int r; int g; int b; bit vs; bit hs; bit den;} exp_t;
    exp_t   p1, p2;
    longint cyc = 0;
    longint m_sr, m_sg, m_sb;
    bit     m_vs_prev, m_busy;
    int     m_gain_r, m_gain_b, m_pend_r, m_pend_b, m_res_r, m_res_b;
    longint t_r, t_b, t_act;

    function automatic int apply_gain(int x, int g);
        int v = (x * g + 128) >>> 8;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int ratio(longint g, longint x, int hold);
        longint q;
        if (x == 0) return hold;
        q = (g * 256) / x;
        return (q > 4095) ? 4095 : int'(q);
    endfunction

    function automatic longint sadd(longint a, int b);
        return (a + b > SMAX) ? SMAX : a + b;
    endfunction

    task automatic model_step();
        int gr, gb;
        cyc++;
        if (reset) begin
            p1 = '{0, 0, 0, 0, 0, 0};
            p2 = p1;
            m_sr = 0; m_sg = 0; m_sb = 0;
            m_vs_prev = 0; m_busy = 0;
            m_gain_r = 256; m_gain_b = 256; m_pend_r = 256; m_pend_b = 256;
            return;
        end
        gr = awb_en ? m_gain_r : 256;
        gb = awb_en ? m_gain_b : 256;
        p2 = p1;
        p1 = '{apply_gain(int'(in_data_R), gr), int'(in_data_G), apply_gain(int'(in_data_B), gb),
               in_vsync, in_hsync, in_den};
        if (m_busy && cyc == t_r) m_pend_r = m_res_r;
        if (m_busy && cyc == t_b) m_pend_b = m_res_b;
        if (m_busy && cyc == t_act) begin
            m_gain_r = m_pend_r; m_gain_b = m_pend_b; m_busy = 0;
        end
        if (in_vsync && !m_vs_prev) begin
            m_res_r = ratio(m_sg, m_sr, m_pend_r);
            m_res_b = ratio(m_sg, m_sb, m_pend_b);
            m_sr = 0; m_sg = 0; m_sb = 0;
            m_busy = 1;
            t_r = cyc + 1 + N; t_b = cyc + 1 + 2 * N; t_act = cyc + 2 + 2 * N;
        end
        m_vs_prev = in_vsync;
        if (in_den && in_data_R != 8'hFF && in_data_G != 8'hFF && in_data_B != 8'hFF) begin
            m_sr = sadd(m_sr, int'(in_data_R));
            m_sg = sadd(m_sg, int'(in_data_G));
            m_sb = sadd(m_sb, int'(in_data_B));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("out_R", out_data_R, p2.r);
        check("out_G", out_data_G, p2.g);
        check("out_B", out_data_B, p2.b);
        check("out_vsync", out_vsync, p2.vs);
        check("out_hsync", out_hsync, p2.hs);
        check("out_den", out_den, p2.den);
        check("gain_R", gain_R, m_gain_r);
        check("gain_B", gain_B, m_gain_b);
        check("awb_busy", awb_busy, m_busy);
    endtask

    task automatic drive_px(input bit den, input int r, input int g, input int b);
        in_den = den;
        in_data_R = 8'(r); in_data_G = 8'(g); in_data_B = 8'(b);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_px(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    function automatic int rnd_ch();
        return ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 254);
    endfunction

    // mode 0: uniform colour; 1: alternating with fully clipped pixels; 2: random data, den gaps, awb_en toggles
    task automatic send_frame(input int w, input int h, input int mode, input int r, input int g, input int b);
        for (int y = 0; y < h; y++) begin
            in_hsync = 1; idle(2); in_hsync = 0;
            for (int x = 0; x < w; x++) begin
                if (mode == 0) drive_px(1, r, g, b);
                else if (mode == 1) begin
                    if (x % 2 == 1) drive_px(1, 255, 255, 255);
                    else drive_px(1, r, g, b);
                end else begin
                    if ($urandom_range(0, 31) == 0) awb_en = ~awb_en;
                    drive_px($urandom_range(0, 7) != 0, rnd_ch(), rnd_ch(), rnd_ch());
                end
            end
            idle(3);
        end
    endtask

    task automatic vs_edge(input int blank);
        in_vsync = 1; idle(2); in_vsync = 0; idle(blank);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1; awb_en = 1; in_vsync = 0; in_hsync = 0; in_den = 0;
        in_data_R = 0; in_data_G = 0; in_data_B = 0;
        tick(); tick(); tick();
        check("rst_out_R", out_data_R, 0);
        check("rst_gain_R", gain_R, 256);
        check("rst_gain_B", gain_B, 256);
        check("rst_busy", awb_busy, 0);
        reset = 0;
        idle(4);

        send_frame(8, 4, 0, 100, 100, 100); vs_edge(80);
        check("gray_gain_R", gain_R, 256); check("gray_gain_B", gain_B, 256);
        send_frame(8, 4, 0, 64, 128, 32); vs_edge(80);
        check("ratio_gain_R", gain_R, 512); check("ratio_gain_B", gain_B, 1024);
        send_frame(8, 4, 0, 64, 128, 32);
        drive_px(0, 200, 10, 10); drive_px(0, 0, 10, 10);
        check("sat_R", out_data_R, 255);
        drive_px(0, 0, 0, 0);
        check("zero_R", out_data_R, 0);
        vs_edge(80);
        send_frame(8, 4, 0, 100, 100, 100); vs_edge(80);
        check("regray_gain_R", gain_R, 256);
        send_frame(8, 4, 1, 64, 128, 32); vs_edge(80);
        check("clip_gain_R", gain_R, 512); check("clip_gain_B", gain_B, 1024);
        send_frame(8, 4, 0, 0, 50, 25); vs_edge(80);
        check("zeroR_hold_R", gain_R, 512); check("zeroR_gain_B", gain_B, 512);
        awb_en = 0;
        send_frame(8, 4, 0, 0, 50, 25);
        check("en0_gain_R", gain_R, 512);
        vs_edge(80);
        check("en0_after_B", gain_B, 512);
        awb_en = 1;

        // second boundary 20 cycles into a division
        in_vsync = 1; idle(1); in_vsync = 0;
        for (int i = 0; i < 8; i++) drive_px(1, 32, 128, 128);
        idle(11);
        in_vsync = 1; idle(1); in_vsync = 0;
        check("restart_busy", awb_busy, 1);
        n = 0;
        do begin idle(1); n++; end while (awb_busy && n < 200);
        check("restart_latency", n, 74);
        check("restart_gain_R", gain_R, 1024); check("restart_gain_B", gain_B, 256);

        // reset 30 cycles into a division
        send_frame(4, 2, 0, 64, 128, 32);
        in_vsync = 1; idle(1); in_vsync = 0; idle(30);
        reset = 1; idle(1); reset = 0;
        check("midrst_gain_R", gain_R, 256); check("midrst_gain_B", gain_B, 256);
        check("midrst_busy", awb_busy, 0);
        idle(4);

        for (int f = 0; f < 12; f++) begin
            awb_en = $urandom_range(0, 1);
            send_frame($urandom_range(4, 16), $urandom_range(2, 6), 2, 0, 0, 0);
            vs_edge($urandom_range(10, 120));
        end
        idle(80);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
